// File: rtl/controller_event_scheduler.sv
// Gamepad event scheduler: debounces a 12-bit button snapshot once per frame, detects presses and
// D-pad auto-repeats, and serialises the resulting events into a small first-word fall-through FIFO.
module controller_event_scheduler #(
    parameter int unsigned STABLE_FRAMES = 2,
    parameter int unsigned REPEAT_DELAY  = 20,
    parameter int unsigned REPEAT_RATE   = 5,
    parameter int unsigned FIFO_DEPTH    = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [11:0] buttons,
    input  logic        frame_done,
    output logic        evt_valid,
    output logic [3:0]  evt_code,
    output logic        evt_repeat,
    input  logic        evt_ready,
    output logic [11:0] held,
    output logic        overflow
);

    localparam int unsigned CNT_W = 2;
    localparam int unsigned TMR_W = $clog2(REPEAT_DELAY + REPEAT_RATE + 1);
    localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);

    typedef enum logic {
        IDLE,
        SCAN
    } state_t;

    state_t                        state_q, state_d;
    logic [11:0]                   held_q, held_d, held_new;
    logic [11:0][CNT_W-1:0]        cnt_q, cnt_d, cnt_new;
    logic [TMR_W-1:0]              timer_q, timer_d, timer_new, timer_inc;
    logic [11:0]                   pend_q, pend_d;
    logic [11:0]                   rflag_q, rflag_d;
    logic [11:0]                   press, rep, rest;
    logic [3:0]                    top_idx;

    logic [FIFO_DEPTH-1:0][4:0]    mem_q, mem_d;
    logic [PTR_W-1:0]              wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [PTR_W:0]                count_q, count_d;
    logic                          overflow_q, overflow_d;
    logic                          push, push_ok, pop, full;
    logic [4:0]                    head;

    // Candidate frame update; only committed when a frame is accepted in IDLE.
    always_comb begin
        held_new  = held_q;
        cnt_new   = cnt_q;
        rep       = '0;
        timer_new = timer_q;
        timer_inc = timer_q + 1'b1;
        for (int i = 0; i < 12; i++) begin
            if (buttons[i] != held_q[i]) begin
                if (cnt_q[i] == CNT_W'(STABLE_FRAMES - 1)) begin
                    held_new[i] = ~held_q[i];
                    cnt_new[i]  = '0;
                end else begin
                    cnt_new[i] = cnt_q[i] + 1'b1;
                end
            end else begin
                cnt_new[i] = '0;
            end
        end
        press = held_new & ~held_q;
        if ((held_new[11:8] != held_q[11:8]) || (held_new[11:8] == 4'b0)) begin
            timer_new = '0;
        end else if (timer_inc == TMR_W'(REPEAT_DELAY)) begin
            timer_new  = timer_inc;
            rep[11:8]  = held_new[11:8];
        end else if (timer_inc == TMR_W'(REPEAT_DELAY + REPEAT_RATE)) begin
            timer_new  = TMR_W'(REPEAT_DELAY);
            rep[11:8]  = held_new[11:8];
        end else begin
            timer_new = timer_inc;
        end
    end

    always_comb begin
        top_idx = '0;
        for (int i = 0; i < 12; i++) begin
            if (pend_q[i]) begin
                top_idx = i[3:0];
            end
        end
        rest = pend_q & ~(12'b1 << top_idx);
    end

    always_comb begin
        state_d = state_q;
        held_d  = held_q;
        cnt_d   = cnt_q;
        timer_d = timer_q;
        pend_d  = pend_q;
        rflag_d = rflag_q;
        push    = 1'b0;
        case (state_q)
            IDLE: begin
                if (frame_done) begin
                    held_d  = held_new;
                    cnt_d   = cnt_new;
                    timer_d = timer_new;
                    pend_d  = press | rep;
                    rflag_d = rep & ~press;
                    state_d = SCAN;
                end
            end
            SCAN: begin
                if (pend_q == 12'b0) begin
                    state_d = IDLE;
                end else begin
                    push   = 1'b1;
                    pend_d = rest;
                    if (rest == 12'b0) begin
                        state_d = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // A full FIFO still accepts a push when the head leaves in the same cycle.
    always_comb begin
        mem_d      = mem_q;
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        count_d    = count_q;
        full       = (count_q == (PTR_W + 1)'(FIFO_DEPTH));
        pop        = evt_valid & evt_ready;
        push_ok    = push & (~full | pop);
        overflow_d = overflow_q | (push & full & ~pop);
        if (push_ok) begin
            mem_d[wr_ptr_q] = {rflag_q[top_idx], top_idx};
            wr_ptr_d        = wr_ptr_q + 1'b1;
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end
        if (push_ok && !pop) begin
            count_d = count_q + 1'b1;
        end else if (!push_ok && pop) begin
            count_d = count_q - 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= IDLE;
            held_q     <= '0;
            cnt_q      <= '0;
            timer_q    <= '0;
            pend_q     <= '0;
            rflag_q    <= '0;
            mem_q      <= '0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            overflow_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            held_q     <= held_d;
            cnt_q      <= cnt_d;
            timer_q    <= timer_d;
            pend_q     <= pend_d;
            rflag_q    <= rflag_d;
            mem_q      <= mem_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            overflow_q <= overflow_d;
        end
    end

    assign head       = mem_q[rd_ptr_q];
    assign evt_valid  = (count_q != '0);
    assign evt_code   = evt_valid ? head[3:0] : 4'b0;
    assign evt_repeat = evt_valid ? head[4] : 1'b0;
    assign held       = held_q;
    assign overflow   = overflow_q;

endmodule

// File: tb/tb_controller_event_scheduler.sv
// Scoreboard bench for controller_event_scheduler: directed frames push expected events into a
// queue; an independent monitor pops and compares every event the consumer accepts.
module tb_controller_event_scheduler;

    logic        clk;
    logic        reset;
    logic [11:0] buttons;
    logic        frame_done;
    logic        evt_valid;
    logic [3:0]  evt_code;
    logic        evt_repeat;
    logic        evt_ready;
    logic [11:0] held;
    logic        overflow;

    int checks;
    int failures;
    int cycle;
    logic [4:0] exp_q[$];
    int         acc_cyc[$];

    controller_event_scheduler dut (
        .clk        (clk),
        .reset      (reset),
        .buttons    (buttons),
        .frame_done (frame_done),
        .evt_valid  (evt_valid),
        .evt_code   (evt_code),
        .evt_repeat (evt_repeat),
        .evt_ready  (evt_ready),
        .held       (held),
        .overflow   (overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cycle <= cycle + 1;

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic expectEvent(input logic [3:0] code, input logic rpt);
        exp_q.push_back({rpt, code});
    endtask

    // One frame strobe, then enough idle cycles for the scan and the FIFO to settle.
    task automatic applyStimulus(input logic [11:0] b);
        @(posedge clk);
        #1;
        buttons    = b;
        frame_done = 1'b1;
        @(posedge clk);
        #1;
        frame_done = 1'b0;
        repeat (15) @(posedge clk);
        #1;
    endtask

    // Monitor: every accepted event must match the head of the expected queue.
    always @(negedge clk) begin
        if (reset && evt_valid && evt_ready) begin
            logic [4:0] e;
            acc_cyc.push_back(cycle);
            checks++;
            if (exp_q.size() == 0) begin
                failures++;
                $display("[TB] FAIL unexpected_event: got code=%0d repeat=%0d, expected none",
                         evt_code, evt_repeat);
            end else begin
                e = exp_q.pop_front();
                if ({evt_repeat, evt_code} !== e) begin
                    failures++;
                    $display("[TB] FAIL event: got code=%0d repeat=%0d, expected code=%0d repeat=%0d",
                             evt_code, evt_repeat, e[3:0], e[4]);
                end
            end
        end
    end

    initial begin
        checks     = 0;
        failures   = 0;
        cycle      = 0;
        reset      = 1'b0;
        buttons    = '0;
        frame_done = 1'b0;
        evt_ready  = 1'b1;
        #1;
        checkOutput("reset_held", 32'(held), 32'h0);
        checkOutput("reset_valid", 32'(evt_valid), 32'h0);
        checkOutput("reset_code", 32'(evt_code), 32'h0);
        checkOutput("reset_repeat", 32'(evt_repeat), 32'h0);
        checkOutput("reset_overflow", 32'(overflow), 32'h0);
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b1;

        // Test 1: button a held three frames flips after the second, one event.
        expectEvent(4'd6, 1'b0);
        applyStimulus(12'h040);
        checkOutput("t1_held_f1", 32'(held), 32'h000);
        applyStimulus(12'h040);
        checkOutput("t1_held_f2", 32'(held), 32'h040);
        applyStimulus(12'h040);
        checkOutput("t1_held_f3", 32'(held), 32'h040);
        applyStimulus(12'h000);
        applyStimulus(12'h000);
        checkOutput("t1_release", 32'(held), 32'h000);

        // Test 2: single-frame glitch on start is filtered.
        applyStimulus(12'h002);
        applyStimulus(12'h000);
        checkOutput("t2_glitch", 32'(held), 32'h000);

        // Frame strobe during SCAN must not be sampled.
        @(posedge clk);
        #1;
        buttons    = 12'h002;
        frame_done = 1'b1;
        @(posedge clk);
        #1;
        @(posedge clk);
        #1;
        frame_done = 1'b0;
        buttons    = 12'h000;
        repeat (15) @(posedge clk);
        #1;
        checkOutput("scan_ignores_frame", 32'(held), 32'h000);
        applyStimulus(12'h000);

        // Test 3: hold up 30 frames; press at frame 2, repeats at frames 22 and 27.
        expectEvent(4'd11, 1'b0);
        expectEvent(4'd11, 1'b1);
        expectEvent(4'd11, 1'b1);
        for (int f = 1; f <= 30; f++) begin
            applyStimulus(12'h800);
            if (f == 1) checkOutput("t3_held_f1", 32'(held), 32'h000);
            if (f == 2) checkOutput("t3_held_f2", 32'(held), 32'h800);
            if (f == 22) checkOutput("t3_rep1_seen", 32'(exp_q.size()), 32'd1);
            if (f == 27) checkOutput("t3_rep2_seen", 32'(exp_q.size()), 32'd0);
        end
        applyStimulus(12'h000);
        applyStimulus(12'h000);
        checkOutput("t3_release", 32'(held), 32'h000);

        // Test 4: up, a, mode in one frame come out 11, 6, 0 on consecutive cycles.
        expectEvent(4'd11, 1'b0);
        expectEvent(4'd6, 1'b0);
        expectEvent(4'd0, 1'b0);
        applyStimulus(12'h841);
        acc_cyc.delete();
        applyStimulus(12'h841);
        checkOutput("t4_count", 32'(acc_cyc.size()), 32'd3);
        if (acc_cyc.size() == 3) begin
            checkOutput("t4_gap1", 32'(acc_cyc[1] - acc_cyc[0]), 32'd1);
            checkOutput("t4_gap2", 32'(acc_cyc[2] - acc_cyc[1]), 32'd1);
        end
        applyStimulus(12'h000);
        applyStimulus(12'h000);
        checkOutput("t4_overflow_clear", 32'(overflow), 32'h0);

        // Test 5: six presses with consumer stalled; four highest survive.
        evt_ready = 1'b0;
        expectEvent(4'd11, 1'b0);
        expectEvent(4'd10, 1'b0);
        expectEvent(4'd9, 1'b0);
        expectEvent(4'd6, 1'b0);
        applyStimulus(12'hE70);
        applyStimulus(12'hE70);
        checkOutput("t5_overflow", 32'(overflow), 32'h1);
        checkOutput("t5_valid", 32'(evt_valid), 32'h1);
        checkOutput("t5_head", 32'(evt_code), 32'd11);
        evt_ready = 1'b1;
        repeat (10) @(posedge clk);
        #1;
        checkOutput("t5_drained", 32'(exp_q.size()), 32'd0);
        applyStimulus(12'h000);
        applyStimulus(12'h000);

        // Test 6: reset in the middle of a scan wipes everything.
        evt_ready = 1'b0;
        applyStimulus(12'hFFF);
        @(posedge clk);
        #1;
        buttons    = 12'hFFF;
        frame_done = 1'b1;
        @(posedge clk);
        #1;
        frame_done = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b0;
        #2;
        checkOutput("t6_held", 32'(held), 32'h0);
        checkOutput("t6_valid", 32'(evt_valid), 32'h0);
        checkOutput("t6_code", 32'(evt_code), 32'h0);
        checkOutput("t6_repeat", 32'(evt_repeat), 32'h0);
        checkOutput("t6_overflow", 32'(overflow), 32'h0);
        @(posedge clk);
        #1;
        reset     = 1'b1;
        evt_ready = 1'b1;
        expectEvent(4'd6, 1'b0);
        applyStimulus(12'h040);
        checkOutput("t6_fresh_f1", 32'(held), 32'h000);
        applyStimulus(12'h040);
        checkOutput("t6_fresh_f2", 32'(held), 32'h040);
        applyStimulus(12'h000);
        applyStimulus(12'h000);

        // Bounded wait for any outstanding expected events.
        for (int i = 0; i < 50 && exp_q.size() != 0; i++) begin
            @(posedge clk);
        end
        #1;
        checkOutput("queue_empty", 32'(exp_q.size()), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
